// File: rtl/cla6_share_arbiter.sv
// Round-robin arbiter sharing one 6-bit carry-lookahead adder among four requesters.
// Each operation walks IDLE (grant) -> CALC (add) -> RESP (hold until accepted).

module cla6_adder (
    input  logic [5:0] a,
    input  logic [5:0] b,
    output logic [5:0] sum
);
    logic [5:0] g;
    logic [5:0] p;
    logic [5:0] c;
    logic       term;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flat OR of generate terms propagated through the bits between.
    always_comb begin
        c    = '0;
        term = 1'b0;
        for (int i = 1; i < 6; i++) begin
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & p[k];
                end
                c[i] = c[i] | term;
            end
        end
    end

    assign sum = p ^ c;
endmodule

module cla6_share_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [6*NUM_REQ-1:0]   req_a,
    input  logic [6*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [5:0]             rsp_sum,
    output logic [1:0]             rsp_id,
    output logic                   busy,
    output logic [7:0]             op_cnt
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t     state;
    logic [1:0] rr_ptr;
    logic [1:0] win;
    logic       any_req;
    logic [1:0] idx;

    logic [5:0] op_a_p0;
    logic [5:0] op_b_p0;
    logic [1:0] owner_p0;
    logic [5:0] sum_p0;

    always_comb begin
        win     = rr_ptr;
        any_req = 1'b0;
        idx     = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = rr_ptr + 2'(k);
            if (!any_req && req_valid[idx]) begin
                win     = idx;
                any_req = 1'b1;
            end
        end
    end

    // rst_n gating keeps the grant low during reset even while requests are pending.
    assign req_ready = (rst_n && state == IDLE && any_req) ? (NUM_REQ'(1) << win) : '0;
    assign busy      = (state != IDLE);

    // Stage p0: operands captured on the grant edge; only ever feed the shared adder.
    always_ff @(posedge clk) begin
        if (state == IDLE && any_req) begin
            op_a_p0  <= req_a[6*win +: 6];
            op_b_p0  <= req_b[6*win +: 6];
            owner_p0 <= win;
        end
    end

    cla6_adder u_cla (
        .a   (op_a_p0),
        .b   (op_b_p0),
        .sum (sum_p0)
    );

    // Stage p1: registered response held until the consumer accepts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 2'd0;
            rsp_valid <= 1'b0;
            rsp_sum   <= 6'd0;
            rsp_id    <= 2'd0;
            op_cnt    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        rr_ptr <= win + 2'd1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rsp_sum   <= sum_p0;
                    rsp_id    <= owner_p0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_cnt    <= op_cnt + 8'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla6_share_arbiter.sv
// Directed bench for cla6_share_arbiter: grants, sums, backpressure, mid-op reset, counter wrap.

module tb_cla6_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [23:0] req_a;
    logic [23:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [5:0]  rsp_sum;
    logic [1:0]  rsp_id;
    logic        busy;
    logic [7:0]  op_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    cla6_share_arbiter #(.NUM_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [5:0] a, input logic [5:0] b);
        req_a[6*i +: 6] = a;
        req_b[6*i +: 6] = b;
    endtask

    // Called shortly after a falling edge with the DUT in IDLE; returns likewise.
    task automatic do_op(input logic [3:0] vld, input int exp_id, input int exp_sum);
        req_valid = vld;
        rsp_ready = 1'b1;
        #1;
        check("grant", req_ready, 32'(4'b0001 << exp_id));
        check("idle_busy", busy, 0);
        @(negedge clk); #1;
        check("calc_busy", busy, 1);
        check("calc_ready", req_ready, 0);
        check("calc_valid", rsp_valid, 0);
        @(negedge clk); #1;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_sum", rsp_sum, exp_sum);
        check("rsp_id", rsp_id, exp_id);
        exp_cnt++;
        @(negedge clk); #1;
        check("done_valid", rsp_valid, 0);
        check("done_cnt", op_cnt, exp_cnt & 255);
        check("done_busy", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 4'b0000;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", rsp_valid, 0);
        check("rst_sum", rsp_sum, 0);
        check("rst_id", rsp_id, 0);
        check("rst_cnt", op_cnt, 0);
        check("rst_busy", busy, 0);
        req_valid = 4'b1111;
        #1;
        check("rst_ready", req_ready, 0);
        req_valid = 4'b0000;
        rst_n = 1'b1;
        #1;
        check("idle_noreq", req_ready, 0);

        // Single request and modulo-64 wrap
        set_op(0, 6'd5, 6'd9);
        do_op(4'b0001, 0, 14);
        set_op(2, 6'd63, 6'd1);
        do_op(4'b0100, 2, 0);

        // Backpressure on requester 1 (rr_ptr is now 3); 40+30 = 70 -> 6
        set_op(1, 6'd40, 6'd30);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        check("bp_grant", req_ready, 4'b0010);
        @(negedge clk);
        req_a = '1;
        req_b = '1;
        req_valid = 4'b1111;
        #1;
        check("bp_calc_busy", busy, 1);
        @(negedge clk); #1;
        check("bp_valid", rsp_valid, 1);
        check("bp_sum", rsp_sum, 6);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk); #1;
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_sum", rsp_sum, 6);
            check("bp_hold_id", rsp_id, 1);
            check("bp_hold_ready", req_ready, 0);
            check("bp_hold_busy", busy, 1);
            check("bp_hold_cnt", op_cnt, 2);
        end
        rsp_ready = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk); #1;
        exp_cnt++;
        check("bp_done_valid", rsp_valid, 0);
        check("bp_done_cnt", op_cnt, 3);

        // Mid-op reset in CALC; rr_ptr is 2 so requester 1 wins here
        req_a = '0;
        req_b = '0;
        set_op(1, 6'd40, 6'd30);
        req_valid = 4'b0010;
        #1;
        check("mr_grant", req_ready, 4'b0010);
        @(negedge clk); #1;
        check("mr_calc_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mr_busy", busy, 0);
        check("mr_valid", rsp_valid, 0);
        check("mr_cnt", op_cnt, 0);
        check("mr_sum", rsp_sum, 0);
        check("mr_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b0000;
        #1;
        check("mr_noresp", rsp_valid, 0);
        exp_cnt = 0;

        // Round robin with all requests held and all operands 1
        for (int i = 0; i < 4; i++) set_op(i, 6'd1, 6'd1);
        do_op(4'b1111, 0, 2);
        do_op(4'b1111, 1, 2);
        do_op(4'b1111, 2, 2);
        do_op(4'b1111, 3, 2);
        do_op(4'b1111, 0, 2);

        // Counter wrap after 256 back-to-back operations
        req_valid = 4'b0000;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        repeat (765) @(negedge clk);
        #1;
        check("wrap_255", op_cnt, 255);
        repeat (3) @(negedge clk);
        #1;
        check("wrap_0", op_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
